// File: rtl/ped_crossing_ctrl.sv
// Push-button pedestrian crossing controller: green/yellow/all-red/walk cycle
// with a latched request lamp, a walk countdown and a flashing-yellow night mode.
module ped_crossing_ctrl #(
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_CLEAR  = 2,
  parameter int T_WALK   = 8,
  parameter int T_FLASH  = 4,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             night,
  output logic             traff_green,
  output logic             traff_yellow,
  output logic             traff_red,
  output logic             ped_green,
  output logic             ped_red,
  output logic             wait_lamp,
  output logic [CNT_W-1:0] walk_cnt
);

  typedef enum logic [2:0] {
    GRN  = 3'd0,
    YEL  = 3'd1,
    CLR  = 3'd2,
    WALK = 3'd3,
    NGT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] G_END    = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_END    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] C_END    = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] W_END    = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] W_LEN    = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] FLASH_AT = CNT_W'(T_WALK - T_FLASH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] flash_ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GRN;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Night overrides every phase expiry except WALK, which always runs to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GRN:  if (night) state_d = NGT;
            else if (cnt_q == G_END && req_q) state_d = YEL;
      YEL:  if (night) state_d = NGT;
            else if (cnt_q == Y_END) state_d = CLR;
      CLR:  if (night) state_d = NGT;
            else if (cnt_q == C_END) state_d = WALK;
      WALK: if (cnt_q == W_END) state_d = night ? NGT : GRN;
      NGT:  if (!night) state_d = GRN;
      default: state_d = GRN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q)                    cnt_d = '0;
    else if (state_q == GRN && cnt_q == G_END) cnt_d = cnt_q;
  end

  always_comb begin
    req_d = req_q;
    if (state_d != state_q && (state_d == WALK || state_d == NGT))
      req_d = 1'b0;
    else if (btn && (state_q == GRN || state_q == YEL || state_q == CLR))
      req_d = 1'b1;
  end

  assign flash_ph = cnt_q - FLASH_AT;

  always_comb begin
    traff_green  = 1'b0;
    traff_yellow = 1'b0;
    traff_red    = 1'b0;
    ped_green    = 1'b0;
    ped_red      = 1'b0;
    walk_cnt     = '0;
    unique case (state_q)
      GRN: begin traff_green  = 1'b1; ped_red = 1'b1; end
      YEL: begin traff_yellow = 1'b1; ped_red = 1'b1; end
      CLR: begin traff_red    = 1'b1; ped_red = 1'b1; end
      WALK: begin
        traff_red = 1'b1;
        walk_cnt  = W_LEN - cnt_q;
        ped_green = (cnt_q < FLASH_AT) ? 1'b1 : flash_ph[0];
      end
      NGT: traff_yellow = cnt_q[0];
      default: begin traff_red = 1'b1; ped_red = 1'b1; end
    endcase
  end

  assign wait_lamp = req_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: a per-cycle vector table for the basic
// request cycle plus hand-written sequences for night mode and mid-phase reset.
module tb_ped_crossing_ctrl;

  localparam logic [4:0] L_G   = 5'b10001; // {tg,ty,tr,pg,pr}
  localparam logic [4:0] L_Y   = 5'b01001;
  localparam logic [4:0] L_R   = 5'b00101;
  localparam logic [4:0] L_W   = 5'b00110;
  localparam logic [4:0] L_WF  = 5'b00100;
  localparam logic [4:0] L_OFF = 5'b00000;
  localparam logic [4:0] L_NY  = 5'b01000;

  logic       clk = 1'b0;
  logic       rst, btn, night;
  logic       traff_green, traff_yellow, traff_red, ped_green, ped_red, wait_lamp;
  logic [5:0] walk_cnt;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic       btn;
    logic       night;
    logic [4:0] leds;
    logic       wl;
    logic [5:0] wc;
  } vec_t;

  vec_t tbl[$];

  ped_crossing_ctrl dut (
    .clk(clk), .rst(rst), .btn(btn), .night(night),
    .traff_green(traff_green), .traff_yellow(traff_yellow), .traff_red(traff_red),
    .ped_green(ped_green), .ped_red(ped_red),
    .wait_lamp(wait_lamp), .walk_cnt(walk_cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic b, input logic n, input logic [4:0] l,
                              input logic w, input logic [5:0] c);
    vec_t v;
    v.btn = b; v.night = n; v.leds = l; v.wl = w; v.wc = c;
    tbl.push_back(v);
  endfunction

  function automatic void rep(input int k, input logic [4:0] l, input logic w);
    for (int i = 0; i < k; i++) add(1'b0, 1'b0, l, w, 6'd0);
  endfunction

  // Expected walk head for walk cycle k (0..7) of the default parameters.
  function automatic logic [4:0] walk_leds(input int k);
    return (k < 4 || (k % 2) == 1) ? L_W : L_WF;
  endfunction

  function automatic void walk_rows(input int btn_at);
    for (int k = 0; k < 8; k++)
      add(k == btn_at, 1'b0, walk_leds(k), 1'b0, 6'(8 - k));
  endfunction

  task automatic chk(input string nm, input logic [4:0] el, input logic ew,
                     input logic [5:0] ec);
    logic [4:0] got;
    got = {traff_green, traff_yellow, traff_red, ped_green, ped_red};
    checks++;
    if (got !== el || wait_lamp !== ew || walk_cnt !== ec) begin
      errs++;
      $display("FAIL %s: got leds=%b wait=%b walk=%0d, want leds=%b wait=%b walk=%0d",
               nm, got, wait_lamp, walk_cnt, el, ew, ec);
    end
  endtask

  task automatic step(input logic b, input logic n);
    btn = b; night = n;
    @(posedge clk); #1;
  endtask

  task automatic stepchk(input string nm, input logic b, input logic n,
                         input logic [4:0] el, input logic ew, input logic [5:0] ec);
    step(b, n);
    chk(nm, el, ew, ec);
  endtask

  initial begin
    // Cycle c = interval after edge c; btn in vector for edge 3 -> lamp from cycle 3.
    rep(2, L_G, 1'b0);
    add(1'b1, 1'b0, L_G, 1'b1, 6'd0);
    rep(6, L_G, 1'b1);
    rep(3, L_Y, 1'b1);
    rep(2, L_R, 1'b1);
    walk_rows(3);                      // btn during WALK must be ignored
    rep(18, L_G, 1'b0);                // cycles 23..40, no repeat crossing
    add(1'b1, 1'b0, L_G, 1'b1, 6'd0);  // late request in saturated GRN
    rep(3, L_Y, 1'b1);
    rep(2, L_R, 1'b1);
    walk_rows(-1);
    rep(12, L_G, 1'b0);

    rst = 1'b1; btn = 1'b0; night = 1'b0;
    #2 chk("reset_async", L_G, 1'b0, 6'd0);
    @(negedge clk); rst = 1'b0;
    chk("reset_release", L_G, 1'b0, 6'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].btn, tbl[i].night);
      chk($sformatf("vec%0d", i + 1), tbl[i].leds, tbl[i].wl, tbl[i].wc);
    end

    // Night asserted during YEL
    stepchk("ny_req",  1'b1, 1'b0, L_G,   1'b1, 6'd0);
    stepchk("ny_yel",  1'b0, 1'b0, L_Y,   1'b1, 6'd0);
    stepchk("ny_ngt0", 1'b0, 1'b1, L_OFF, 1'b0, 6'd0);
    stepchk("ny_ngt1", 1'b0, 1'b1, L_NY,  1'b0, 6'd0);
    stepchk("ny_ngt2", 1'b1, 1'b1, L_OFF, 1'b0, 6'd0);
    stepchk("ny_ngt3", 1'b0, 1'b1, L_NY,  1'b0, 6'd0);
    stepchk("ny_grn",  1'b0, 1'b0, L_G,   1'b0, 6'd0);
    // Counter restarted on GRN entry: full minimum green again
    for (int i = 0; i < 9; i++)
      stepchk($sformatf("ny_min%0d", i), i == 0, 1'b0, L_G, 1'b1, 6'd0);
    stepchk("ny_yel2", 1'b0, 1'b0, L_Y, 1'b1, 6'd0);

    // Night asserted mid-WALK: walk completes, then NGT
    for (int i = 0; i < 2; i++) stepchk("nw_yel", 1'b0, 1'b0, L_Y, 1'b1, 6'd0);
    for (int i = 0; i < 2; i++) stepchk("nw_clr", 1'b0, 1'b0, L_R, 1'b1, 6'd0);
    for (int k = 0; k < 8; k++)
      stepchk($sformatf("nw_walk%0d", k), 1'b0, k >= 3, walk_leds(k), 1'b0, 6'(8 - k));
    stepchk("nw_ngt0", 1'b0, 1'b1, L_OFF, 1'b0, 6'd0);
    stepchk("nw_ngt1", 1'b1, 1'b1, L_NY,  1'b0, 6'd0);
    stepchk("nw_ngt2", 1'b1, 1'b1, L_OFF, 1'b0, 6'd0);
    stepchk("nw_grn",  1'b0, 1'b0, L_G,   1'b0, 6'd0);

    // Reset pulsed mid-CLR
    for (int i = 0; i < 9; i++)
      stepchk("rc_grn", i == 0, 1'b0, L_G, 1'b1, 6'd0);
    for (int i = 0; i < 3; i++) stepchk("rc_yel", 1'b0, 1'b0, L_Y, 1'b1, 6'd0);
    stepchk("rc_clr", 1'b0, 1'b0, L_R, 1'b1, 6'd0);
    #3 rst = 1'b1;
    #1 chk("rc_async", L_G, 1'b0, 6'd0);
    @(posedge clk); #1;
    chk("rc_hold", L_G, 1'b0, 6'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++)
      stepchk($sformatf("rc_min%0d", i), i == 0, 1'b0, L_G, 1'b1, 6'd0);
    stepchk("rc_yel2", 1'b0, 1'b0, L_Y, 1'b1, 6'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
